hex_operand_entry: RTL and testbench

Operator-input block for the ALU datapath and the input counterpart of the two-digit hex result display. It debounces a raw "push" button and a raw "clear" button. It assembles two 4-bit switch nibbles, high digit first, into an 8-bit operand. It presents the operand with a valid/ack handshake to the downstream register or ALU. The current digit count and partial value are exposed so they can be shown on the 7-segment display during entry.

---
 rtl/hex_operand_entry.sv | 128 ++++++++++++
 tb/tb_hex_operand_entry.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hex_operand_entry.sv
// Operator entry for the ALU datapath: debounces Push/Clear and assembles two
// hex nibbles (high digit first) into an 8-bit operand offered with valid/ack.
module hex_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Push,
  input  logic       Clear,
  input  logic [3:0] Nibble,
  input  logic       Ack,
  output logic [7:0] Operand,
  output logic [1:0] Digit_Count,
  output logic       Operand_Valid
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES);

  // Bit 0 carries Push, bit 1 carries Clear through the shared debounce path.
  logic [1:0]  raw;
  logic [1:0]  meta_q, meta_d;
  logic [1:0]  sync_q, sync_d;
  logic [1:0]  stable_q, stable_d;
  logic [1:0]  prev_q, prev_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  logic [1:0]  evt;
  logic        push_evt;
  logic        clear_evt;

  state_t      state_q, state_d;
  logic [7:0]  operand_q, operand_d;
  logic        valid_q, valid_d;

  assign raw = {Clear, Push};

  always_comb begin
    meta_d   = raw;
    sync_d   = meta_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        // Count reaching the limit flips the level on the following edge.
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign evt       = stable_q & ~prev_q;
  assign push_evt  = evt[0];
  assign clear_evt = evt[1];

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    valid_d   = valid_q;
    if (clear_evt) begin
      state_d   = EMPTY;
      operand_d = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_evt) begin
            operand_d = {4'h0, Nibble};
            state_d   = HALF;
          end
        end
        HALF: begin
          if (push_evt) begin
            operand_d = {operand_q[3:0], Nibble};
            state_d   = FULL;
            valid_d   = 1'b1;
          end
        end
        FULL: begin
          if (Ack) begin
            state_d = EMPTY;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = EMPTY;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      meta_q    <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      cnt_q     <= '{default: '0};
      state_q   <= EMPTY;
      operand_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      operand_q <= operand_d;
      valid_q   <= valid_d;
    end
  end

  assign Operand       = operand_q;
  assign Digit_Count   = state_q;
  assign Operand_Valid = valid_q;

endmodule

// File: tb/tb_hex_operand_entry.sv
// Directed bench for hex_operand_entry with DEBOUNCE_CYCLES=4.
module tb_hex_operand_entry;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] nib = 4'h0;
  logic       ack = 1'b0;
  logic [7:0] op;
  logic [1:0] dc;
  logic       vld;

  int total = 0;
  int bad   = 0;

  hex_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK          (clk),
    .Reset        (rst),
    .Push         (push),
    .Clear        (clr),
    .Nibble       (nib),
    .Ack          (ack),
    .Operand      (op),
    .Digit_Count  (dc),
    .Operand_Valid(vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Push rises before edge 0; digit lands after edge D+3.
  task automatic press(input logic [3:0] n);
    nib  = n;
    push = 1'b1;
    repeat (D + 4) tick();
  endtask

  task automatic release_all();
    push = 1'b0;
    clr  = 1'b0;
    repeat (D + 4) tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_op", op, 8'h00);
    chk("reset_dc", {6'd0, dc}, 8'd0);
    chk("reset_vld", {7'd0, vld}, 8'd0);

    // First press: exact latency boundary
    nib  = 4'hA;
    push = 1'b1;
    repeat (D + 3) tick();
    chk("lat_early_dc", {6'd0, dc}, 8'd0);
    tick();
    chk("lat_op", op, 8'h0A);
    chk("lat_dc", {6'd0, dc}, 8'd1);
    release_all();

    // Second press: valid rises with Digit_Count=2
    nib  = 4'h5;
    push = 1'b1;
    repeat (D + 3) tick();
    chk("second_early_vld", {7'd0, vld}, 8'd0);
    tick();
    chk("second_op", op, 8'hA5);
    chk("second_dc", {6'd0, dc}, 8'd2);
    chk("second_vld", {7'd0, vld}, 8'd1);
    release_all();

    // Push in FULL is dropped
    press(4'hF);
    release_all();
    chk("full_push_op", op, 8'hA5);
    chk("full_push_vld", {7'd0, vld}, 8'd1);
    chk("full_push_dc", {6'd0, dc}, 8'd2);

    // One-cycle Ack
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_vld", {7'd0, vld}, 8'd0);
    chk("ack_dc", {6'd0, dc}, 8'd0);
    chk("ack_op_kept", op, 8'hA5);

    press(4'h7);
    release_all();
    chk("after_ack_op", op, 8'h07);
    chk("after_ack_dc", {6'd0, dc}, 8'd1);

    // Ack outside FULL ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_half_dc", {6'd0, dc}, 8'd1);

    clr = 1'b1;
    repeat (D + 4) tick();
    chk("clear1_op", op, 8'h00);
    chk("clear1_dc", {6'd0, dc}, 8'd0);
    release_all();

    // Bouncing press yields one event
    nib = 4'h3;
    for (int i = 0; i < 10; i++) begin
      push = (i % 2 == 0);
      tick();
    end
    push = 1'b1;
    repeat (D + 4 + 20) tick();
    chk("bounce_op", op, 8'h03);
    chk("bounce_dc", {6'd0, dc}, 8'd1);
    release_all();

    // Short pulses rejected
    nib = 4'hE;
    for (int w = 1; w <= 3; w++) begin
      push = 1'b1;
      repeat (w) tick();
      push = 1'b0;
      repeat (10) tick();
      chk($sformatf("glitch%0d_op", w), op, 8'h03);
      chk($sformatf("glitch%0d_dc", w), {6'd0, dc}, 8'd1);
      chk($sformatf("glitch%0d_vld", w), {7'd0, vld}, 8'd0);
    end

    clr = 1'b1;
    repeat (D + 4) tick();
    release_all();
    press(4'hC);
    release_all();
    chk("c_op", op, 8'h0C);
    chk("c_dc", {6'd0, dc}, 8'd1);
    clr = 1'b1;
    repeat (D + 4) tick();
    release_all();
    chk("clear2_op", op, 8'h00);
    chk("clear2_dc", {6'd0, dc}, 8'd0);

    // Clear and push events in the same cycle
    nib  = 4'hB;
    push = 1'b1;
    clr  = 1'b1;
    repeat (D + 6) tick();
    chk("both_op", op, 8'h00);
    chk("both_dc", {6'd0, dc}, 8'd0);
    chk("both_vld", {7'd0, vld}, 8'd0);
    release_all();

    // Reset mid-entry and mid-debounce, Push still held
    press(4'h9);
    release_all();
    chk("pre_rst_dc", {6'd0, dc}, 8'd1);
    nib  = 4'h6;
    push = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_op", op, 8'h00);
    chk("rst_dc", {6'd0, dc}, 8'd0);
    chk("rst_vld", {7'd0, vld}, 8'd0);
    repeat (D + 3) tick();
    chk("rst_early_dc", {6'd0, dc}, 8'd0);
    tick();
    chk("rst_held_op", op, 8'h06);
    chk("rst_held_dc", {6'd0, dc}, 8'd1);
    release_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
